// File: rtl/music_pkg.sv
// Shared definitions for the music playback sequencer.
//   NOTE_W / ADDR_W  : note-code and ROM-address widths
//   NOTE_REST        : note code that means "silence for this beat"
//   state_t          : sequencer state encoding
//   DEF_*            : default timing constants (12 MHz clock, 0.5 s beat)
package music_pkg;

  localparam int NOTE_W = 5;
  localparam int ADDR_W = 8;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int DEF_BEAT_CYCLES = 6000000;
  localparam int DEF_GAP_CYCLES  = 600000;
  localparam int DEF_SONG_LEN    = 48;
  localparam int DEF_CNT_W       = 23;

endpackage

// File: rtl/music_beat_timer.sv
// Beat timer for the music sequencer.
// Counts clk cycles within a beat and flags the two interesting positions:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (start / stop)
//   run        : advance the count this cycle (low while paused or idle)
//   gap_hit    : count is on the last sounded cycle of the beat
//   end_hit    : count is on the last cycle of the beat (beat boundary)
// The count wraps to 0 by itself on the boundary, so a new beat always
// begins at 0 whether playback continues, loops or ends.
module music_beat_timer #(
  parameter int BEAT_CYCLES = 6000000,
  parameter int GAP_CYCLES  = 600000,
  parameter int CNT_W       = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic gap_hit,
  output logic end_hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= end_hit ? '0 : count + 1'b1;
    end
  end

  // With GAP_CYCLES == 0 both compares coincide; the sequencer then skips
  // the GAP state and takes the boundary straight from PLAY.
  assign gap_hit = (count == CNT_W'(BEAT_CYCLES - GAP_CYCLES - 1));
  assign end_hit = (count == CNT_W'(BEAT_CYCLES - 1));

endmodule

// File: rtl/music_seq_ctrl.sv
// Playback sequencer for an 8-bit-address, 5-bit-note music ROM.
// Steps the ROM address once per beat, latches the note for the tone
// generator, and silences the last GAP_CYCLES of every beat so repeated
// notes re-attack.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, (re)start from address 0 (also clears a pause)
//   stop       : pulse, abort to IDLE without done
//   pause      : pulse, toggle PLAY/GAP <-> PAUSE (ignored in IDLE)
//   loop_en    : level, wrap to address 0 after the last entry
//   rom_addr   : ROM address (next-cycle address, see below)
//   rom_data   : ROM note code for rom_addr, combinational
//   note       : registered note code
//   note_on    : registered "sound the note"
//   beat_tick  : registered pulse on the first cycle of each beat
//   busy       : state is not IDLE
//   done       : registered pulse when a non-looped song ends
//
// Handshake: there are no valid/ready pairs; start/stop/pause are one-cycle
// pulses acted on at the next rising edge with priority stop > start > pause,
// and rom_data is assumed valid in the same cycle rom_addr is presented.
//
// rom_addr carries the address the address register is about to load, so
// the ROM already returns the new beat's note on the cycle the note register
// loads it; note and rom_addr therefore agree on every beat_tick cycle.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int SONG_LEN    = DEF_SONG_LEN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note,
  output logic              note_on,
  output logic              beat_tick,
  output logic              busy,
  output logic              done
);

  state_t              state_q, state_d;
  state_t              resume_q, resume_d;   // sub-state to return to from PAUSE
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                note_on_q, note_on_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  logic gap_hit, end_hit;
  logic running, boundary, last, song_end;
  logic tmr_clear, tmr_run;

  assign running  = (state_q == ST_PLAY) || (state_q == ST_GAP);
  assign boundary = end_hit &&
                    ((state_q == ST_GAP) || ((state_q == ST_PLAY) && (GAP_CYCLES == 0)));
  assign last     = (addr_q == ADDR_W'(SONG_LEN - 1));
  assign song_end = boundary && last && !loop_en;

  // A pause pulse freezes the count on the cycle it arrives, unless that
  // cycle is a boundary: the boundary completes first, then the freeze.
  assign tmr_clear = stop || start;
  assign tmr_run   = running && !stop && !start && (!pause || boundary);

  music_beat_timer #(
    .BEAT_CYCLES (BEAT_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .gap_hit (gap_hit),
    .end_hit (end_hit)
  );

  // Address next-state kept in its own process: rom_data depends on it, and
  // the note next-state below depends on rom_data.
  always_comb begin
    addr_d = addr_q;
    if (stop || start) begin
      addr_d = '0;
    end else if (boundary) begin
      // Last entry goes to 0 both when looping and when the song ends.
      addr_d = last ? '0 : addr_q + 1'b1;
    end
  end

  assign rom_addr = addr_d;

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    note_d    = note_q;
    note_on_d = note_on_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      resume_d  = ST_PLAY;
      note_d    = NOTE_REST;
      note_on_d = 1'b0;
    end else if (start) begin
      state_d   = ST_PLAY;
      resume_d  = ST_PLAY;
      note_d    = rom_data;
      note_on_d = (rom_data != NOTE_REST);
      tick_d    = 1'b1;
    end else begin
      case (state_q)
        ST_PLAY, ST_GAP: begin
          if (song_end) begin
            state_d   = ST_IDLE;
            note_d    = NOTE_REST;
            note_on_d = 1'b0;
            done_d    = 1'b1;
          end else if (boundary) begin
            state_d   = ST_PLAY;
            note_d    = rom_data;
            note_on_d = (rom_data != NOTE_REST);
            tick_d    = 1'b1;
            if (pause) begin
              state_d   = ST_PAUSE;
              resume_d  = ST_PLAY;
              note_on_d = 1'b0;
            end
          end else if (pause) begin
            state_d   = ST_PAUSE;
            resume_d  = state_q;
            note_on_d = 1'b0;
          end else if ((state_q == ST_PLAY) && gap_hit && (GAP_CYCLES != 0)) begin
            state_d   = ST_GAP;
            note_on_d = 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d   = resume_q;
            note_on_d = (resume_q == ST_PLAY) && (note_q != NOTE_REST);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      resume_q  <= ST_PLAY;
      addr_q    <= '0;
      note_q    <= NOTE_REST;
      note_on_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      note_on_q <= note_on_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign note      = note_q;
  assign note_on   = note_on_q;
  assign beat_tick = tick_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with a 10-cycle beat, 2-cycle gap and an
// 8-entry song. Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a period after the rising edge that produced them.
module tb_music_seq_ctrl;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic       loop_en;
  logic [7:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] note;
  logic       note_on;
  logic       beat_tick;
  logic       busy;
  logic       done;

  logic [4:0] rom [0:7];

  int checks = 0;
  int errors = 0;

  assign rom_data = (rom_addr < 8'd8) ? rom[rom_addr[2:0]] : 5'd0;

  music_seq_ctrl #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .SONG_LEN    (LEN),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .note_on   (note_on),
    .beat_tick (beat_tick),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver helpers
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rom[0] = 5'd8;  rom[1] = 5'd8;  rom[2] = 5'd12; rom[3] = 5'd12;
    rom[4] = 5'd13; rom[5] = 5'd13; rom[6] = 5'd12; rom[7] = 5'd0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;

    // reset values
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_note", note, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_tick", beat_tick, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_busy", busy, 0);

    // basic single-shot playback: 8 high / 2 low per beat, last beat a rest
    start = 1'b1; cyc(1); start = 1'b0;
    for (int b = 0; b < LEN; b++) begin
      for (int c = 0; c < BEAT; c++) begin
        if (c == 0) begin
          chk("play_tick", beat_tick, 1);
          chk("play_addr", rom_addr, b);
        end else begin
          chk("play_notick", beat_tick, 0);
        end
        chk("play_note", note, rom[b]);
        chk("play_note_on", note_on, (c < BEAT - GAP) && (rom[b] != 5'd0));
        chk("play_nodone", done, 0);
        chk("play_busy", busy, 1);
        cyc(1);
      end
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_addr", rom_addr, 0);
    chk("end_note", note, 0);
    chk("end_note_on", note_on, 0);
    cyc(1);
    chk("end_done_once", done, 0);

    // looped playback across two and a half passes
    loop_en = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    for (int b = 0; b < 20; b++) begin
      for (int c = 0; c < BEAT; c++) begin
        if (c == 0) begin
          chk("loop_tick", beat_tick, 1);
          chk("loop_addr", rom_addr, b % LEN);
          chk("loop_note", note, rom[b % LEN]);
        end
        chk("loop_nodone", done, 0);
        chk("loop_busy", busy, 1);
        cyc(1);
      end
    end
    stop = 1'b1; cyc(1); stop = 1'b0;
    loop_en = 1'b0;
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_done", done, 0);

    // pause at cycle 3 of beat 2, resume 25 cycles later
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(2 * BEAT + 3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    for (int i = 0; i < 25; i++) begin
      chk("pause_note_on", note_on, 0);
      chk("pause_addr", rom_addr, 2);
      chk("pause_note", note, 12);
      chk("pause_notick", beat_tick, 0);
      chk("pause_busy", busy, 1);
      cyc(1);
    end
    pause = 1'b1; cyc(1); pause = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("resume_note_on", note_on, i < 5);
      chk("resume_notick", beat_tick, 0);
      chk("resume_note", note, 12);
      cyc(1);
    end
    chk("resume_tick", beat_tick, 1);
    chk("resume_addr", rom_addr, 3);
    chk("resume_next_note", note, 12);

    // stop mid beat 4
    cyc(BEAT + 4);
    chk("pre_stop_busy", busy, 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_note", note, 0);
    chk("stop_note_on", note_on, 0);
    chk("stop_addr", rom_addr, 0);
    chk("stop_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stop_nodone", done, 0);
    end
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("idle_pause_ignored", busy, 0);

    // start and pause together: start wins
    start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
    chk("sp_busy", busy, 1);
    chk("sp_note", note, 8);
    chk("sp_note_on", note_on, 1);
    chk("sp_tick", beat_tick, 1);
    chk("sp_addr", rom_addr, 0);
    cyc(1);
    chk("sp_not_paused", note_on, 1);

    // asynchronous reset in the middle of the beat-1 gap
    cyc(BEAT + 7);
    chk("gap_note_on", note_on, 0);
    chk("gap_note", note, 8);
    chk("gap_addr", rom_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_note", note, 0);
    chk("arst_note_on", note_on, 0);
    chk("arst_tick", beat_tick, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", rom_addr, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_busy", busy, 0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
